// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg
// Shared definitions for the RV64M divide/remainder issue controller:
// datapath width, funct3 encodings, FSM state type, reset/zero constants
// and small decode helpers used by the controller and its sign-fix logic.
package div_issue_ctrl_pkg;

  localparam int XLEN = 64;
  localparam int WORD = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic            RST_ACTIVE = 1'b1;
  localparam logic [XLEN-1:0] ZERO_WORD  = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_RESP
  } state_e;

  function automatic logic isSignedOp(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic isRemOp(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  // W forms only look at the low word; signed ops sign-extend it so that
  // bit 63 always carries the operand sign for the magnitude logic.
  function automatic logic [XLEN-1:0] reduceOperand(input logic [XLEN-1:0] v,
                                                    input logic            word,
                                                    input logic            sgn);
    if (!word) begin
      return v;
    end
    if (sgn) begin
      return {{(XLEN-WORD){v[WORD-1]}}, v[WORD-1:0]};
    end
    return {{(XLEN-WORD){1'b0}}, v[WORD-1:0]};
  endfunction

endpackage

// File: rtl/div_issue_ctrl_sign_fix.sv
// div_sign_fix
// Purely combinational helper for the divide controller.
//   a_i, b_i       : reduced dividend / divisor (already word-reduced)
//   signed_i       : operation is DIV/REM (signed)
//   sel_rem_i      : return remainder instead of quotient
//   word_i         : W form, result sign-extended from bit 31
//   quot_i, remainder_i : unsigned core results
//   mag_a_o, mag_b_o    : unsigned magnitudes handed to the core
//   special_o      : divide-by-zero or signed overflow, result needs no core
//   result_o       : final, sign-corrected and extended result
module div_sign_fix
  import div_issue_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  input  logic            sel_rem_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] remainder_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            special_o,
  output logic [XLEN-1:0] result_o
);

  logic            negA;
  logic            negB;
  logic            divZero;
  logic            overflow;
  logic [XLEN-1:0] mostNeg;
  logic [XLEN-1:0] quotFix;
  logic [XLEN-1:0] remFix;
  logic [XLEN-1:0] pick;

  // Special results bypass negation entirely: for divide-by-zero the
  // remainder is the dividend and the quotient is all ones; for overflow
  // the quotient is the dividend itself. Both are already in final form
  // apart from the W-form sign extension applied at the end.
  always_comb begin
    negA     = signed_i & a_i[XLEN-1];
    negB     = signed_i & b_i[XLEN-1];
    mag_a_o  = negA ? (ZERO_WORD - a_i) : a_i;
    mag_b_o  = negB ? (ZERO_WORD - b_i) : b_i;

    mostNeg  = word_i ? {{(XLEN-WORD+1){1'b1}}, {(WORD-1){1'b0}}}
                      : {1'b1, {(XLEN-1){1'b0}}};
    divZero  = (b_i == ZERO_WORD);
    overflow = signed_i & (a_i == mostNeg) & (b_i == {XLEN{1'b1}});
    special_o = divZero | overflow;

    if (divZero) begin
      quotFix = {XLEN{1'b1}};
      remFix  = a_i;
    end else if (overflow) begin
      quotFix = a_i;
      remFix  = ZERO_WORD;
    end else begin
      quotFix = (negA ^ negB) ? (ZERO_WORD - quot_i) : quot_i;
      remFix  = negA ? (ZERO_WORD - remainder_i) : remainder_i;
    end

    pick     = sel_rem_i ? remFix : quotFix;
    result_o = word_i ? {{(XLEN-WORD){pick[WORD-1]}}, pick[WORD-1:0]} : pick;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// Execute-stage requester for the RV64M divide/remainder path.
//   clk, rst               : clock, synchronous active-high reset
//   ex_valid/ex_ready      : request handshake (ex_funct3, ex_word, ex_rs1,
//                            ex_rs2, ex_rd)
//   flush                  : abort whatever is in flight
//   stall                  : high whenever an operation is in flight
//   core_start/core_abort  : launch / cancel pulses to the divider core
//   core_dividend/divisor  : unsigned magnitudes for the core
//   core_done, core_quot, core_rem : core completion and results
//   wb_valid/wb_ready      : response handshake (wb_data, wb_rd)
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_word,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall,
  output logic            core_start,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  output logic            core_abort,
  input  logic            core_done,
  input  logic [XLEN-1:0] core_quot,
  input  logic [XLEN-1:0] core_rem,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd
);

  state_e          state_q;
  logic [XLEN-1:0] opA_q;
  logic [XLEN-1:0] opB_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic            signed_q;
  logic            selRem_q;
  logic            word_q;
  logic [4:0]      rd_q;
  logic            ex_ready_q;
  logic            core_start_q;
  logic            core_abort_q;
  logic [XLEN-1:0] core_dividend_q;
  logic [XLEN-1:0] core_divisor_q;
  logic            wb_valid_q;
  logic [XLEN-1:0] wb_data_q;
  logic [4:0]      wb_rd_q;

  logic            exSigned;
  logic            exSelRem;
  logic [XLEN-1:0] exA;
  logic [XLEN-1:0] exB;
  logic            inFix;
  logic [XLEN-1:0] fixA;
  logic [XLEN-1:0] fixB;
  logic [XLEN-1:0] fixQuot;
  logic [XLEN-1:0] fixRem;
  logic            fixSigned;
  logic            fixSelRem;
  logic            fixWord;
  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;
  logic            special;
  logic [XLEN-1:0] result_d;

  // One sign-fix instance serves two purposes: in IDLE it looks at the
  // incoming request (magnitudes for the core, special-case detection and
  // the special-case result); in FIX it looks at the registered operands
  // and the captured core results.
  always_comb begin
    exSigned  = isSignedOp(ex_funct3);
    exSelRem  = isRemOp(ex_funct3);
    exA       = reduceOperand(ex_rs1, ex_word, exSigned);
    exB       = reduceOperand(ex_rs2, ex_word, exSigned);
    inFix     = (state_q == ST_FIX);
    fixA      = inFix ? opA_q    : exA;
    fixB      = inFix ? opB_q    : exB;
    fixSigned = inFix ? signed_q : exSigned;
    fixSelRem = inFix ? selRem_q : exSelRem;
    fixWord   = inFix ? word_q   : ex_word;
    fixQuot   = inFix ? quot_q   : ZERO_WORD;
    fixRem    = inFix ? rem_q    : ZERO_WORD;
  end

  div_sign_fix u_signFix (
    .a_i         (fixA),
    .b_i         (fixB),
    .signed_i    (fixSigned),
    .sel_rem_i   (fixSelRem),
    .word_i      (fixWord),
    .quot_i      (fixQuot),
    .remainder_i (fixRem),
    .mag_a_o     (magA),
    .mag_b_o     (magB),
    .special_o   (special),
    .result_o    (result_d)
  );

  // Flush overrides everything, including a coincident core_done or
  // wb_ready; the abort pulse only matters if the core is actually busy.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q         <= ST_IDLE;
      opA_q           <= ZERO_WORD;
      opB_q           <= ZERO_WORD;
      quot_q          <= ZERO_WORD;
      rem_q           <= ZERO_WORD;
      signed_q        <= 1'b0;
      selRem_q        <= 1'b0;
      word_q          <= 1'b0;
      rd_q            <= '0;
      ex_ready_q      <= 1'b1;
      core_start_q    <= 1'b0;
      core_abort_q    <= 1'b0;
      core_dividend_q <= ZERO_WORD;
      core_divisor_q  <= ZERO_WORD;
      wb_valid_q      <= 1'b0;
      wb_data_q       <= ZERO_WORD;
      wb_rd_q         <= '0;
    end else begin
      core_start_q <= 1'b0;
      core_abort_q <= 1'b0;
      if (flush) begin
        core_abort_q <= (state_q == ST_RUN);
        state_q      <= ST_IDLE;
        ex_ready_q   <= 1'b1;
        wb_valid_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ex_valid) begin
              opA_q      <= exA;
              opB_q      <= exB;
              signed_q   <= exSigned;
              selRem_q   <= exSelRem;
              word_q     <= ex_word;
              rd_q       <= ex_rd;
              ex_ready_q <= 1'b0;
              if (special) begin
                wb_data_q  <= result_d;
                wb_rd_q    <= ex_rd;
                wb_valid_q <= 1'b1;
                state_q    <= ST_RESP;
              end else begin
                core_dividend_q <= magA;
                core_divisor_q  <= magB;
                core_start_q    <= 1'b1;
                state_q         <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (core_done) begin
              quot_q  <= core_quot;
              rem_q   <= core_rem;
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            wb_data_q  <= result_d;
            wb_rd_q    <= rd_q;
            wb_valid_q <= 1'b1;
            state_q    <= ST_RESP;
          end
          ST_RESP: begin
            if (wb_ready) begin
              wb_valid_q <= 1'b0;
              ex_ready_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            ex_ready_q <= 1'b1;
            wb_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ex_ready      = ex_ready_q;
  assign stall         = (state_q != ST_IDLE);
  assign core_start    = core_start_q;
  assign core_abort    = core_abort_q;
  assign core_dividend = core_dividend_q;
  assign core_divisor  = core_divisor_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl
// Drives directed and randomized divide requests, plays the role of the
// divider core, and checks every cycle against a reference model built
// from RISC-V divide semantics and the handshake latency rules.
module tb_div_issue_ctrl;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [2:0]  ex_funct3 = DIV;
  logic        ex_word = 1'b0;
  logic [63:0] ex_rs1 = '0;
  logic [63:0] ex_rs2 = '0;
  logic [4:0]  ex_rd = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        core_start;
  logic [63:0] core_dividend;
  logic [63:0] core_divisor;
  logic        core_abort;
  logic        core_done = 1'b0;
  logic [63:0] core_quot = '0;
  logic [63:0] core_rem = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  bit          modelOn = 1'b0;
  bit          honourAbort = 1'b1;
  int          coreLatency = 3;

  div_issue_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_funct3     (ex_funct3),
    .ex_word       (ex_word),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .flush         (flush),
    .stall         (stall),
    .core_start    (core_start),
    .core_dividend (core_dividend),
    .core_divisor  (core_divisor),
    .core_abort    (core_abort),
    .core_done     (core_done),
    .core_quot     (core_quot),
    .core_rem      (core_rem),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // RISC-V M-extension result, straight from the ISA definition.
  function automatic logic [63:0] refResult(input logic [2:0] f3, input logic w,
                                            input logic [63:0] x, input logic [63:0] y);
    logic        sgn;
    logic [31:0] a32, b32, q32, r32, p32;
    logic [63:0] q64, r64, p64;
    sgn = (f3 == DIV) || (f3 == REM);
    if (w) begin
      a32 = x[31:0];
      b32 = y[31:0];
      if (b32 == 32'd0) begin
        q32 = '1;
        r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32;
        r32 = '0;
      end else if (sgn) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      p32 = f3[1] ? r32 : q32;
      return {{32{p32[31]}}, p32};
    end
    if (y == 64'd0) begin
      q64 = '1;
      r64 = x;
    end else if (sgn && x == 64'h8000_0000_0000_0000 && y == '1) begin
      q64 = x;
      r64 = '0;
    end else if (sgn) begin
      q64 = $signed(x) / $signed(y);
      r64 = $signed(x) % $signed(y);
    end else begin
      q64 = x / y;
      r64 = x % y;
    end
    p64 = f3[1] ? r64 : q64;
    return p64;
  endfunction

  function automatic logic [63:0] refMag(input logic [2:0] f3, input logic w, input logic [63:0] x);
    logic        sgn;
    logic [63:0] v;
    sgn = (f3 == DIV) || (f3 == REM);
    if (w) v = sgn ? {{32{x[31]}}, x[31:0]} : {32'd0, x[31:0]};
    else   v = x;
    if (sgn && v[63]) v = -v;
    return v;
  endfunction

  function automatic bit refSpecial(input logic [2:0] f3, input logic w,
                                    input logic [63:0] x, input logic [63:0] y);
    bit sgn;
    sgn = (f3 == DIV) || (f3 == REM);
    if (w) return (y[31:0] == 32'd0) ||
                  (sgn && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
    return (y == 64'd0) || (sgn && x == 64'h8000_0000_0000_0000 && y == '1);
  endfunction

  // Divider core stand-in: answers each launch after coreLatency cycles
  // with the true unsigned quotient/remainder of the operands it was given.
  typedef struct {
    int unsigned due;
    logic [63:0] q;
    logic [63:0] r;
  } done_t;
  done_t pend[$];

  always @(negedge clk) begin : coreAccept
    done_t e;
    if (core_abort && honourAbort) pend.delete();
    if (core_start) begin
      e.due = cyc + coreLatency;
      if (core_divisor == 64'd0) begin
        e.q = '1;
        e.r = core_dividend;
      end else begin
        e.q = core_dividend / core_divisor;
        e.r = core_dividend % core_divisor;
      end
      pend.push_back(e);
    end
  end

  always begin : coreReply
    @(posedge clk);
    #1;
    core_done = 1'b0;
    core_quot = {$urandom, $urandom};
    core_rem  = {$urandom, $urandom};
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].due == cyc) begin
        core_done = 1'b1;
        core_quot = pend[i].q;
        core_rem  = pend[i].r;
        pend.delete(i);
        break;
      end
    end
  end

  // Reference model: tracks only whether the controller is waiting on the
  // core, one cycle past completion, or offering a result, and what that
  // result and the core operands must be. Inputs of cycle c decide what
  // the registered outputs of cycle c+1 must look like.
  bit          mRun = 1'b0;
  bit          mFix = 1'b0;
  bit          mValid = 1'b0;
  bit          mStart = 1'b0;
  bit          mAbort = 1'b0;
  logic [63:0] mData = '0;
  logic [4:0]  mRd = '0;
  logic [63:0] mDiv = '0;
  logic [63:0] mDvs = '0;
  logic [63:0] pendData = '0;
  logic [4:0]  pendRd = '0;

  always @(negedge clk) begin : compare
    bit mIdle;
    if (modelOn) begin
      mIdle = !(mRun || mFix || mValid);
      checkOutput("ex_ready", {63'd0, ex_ready}, {63'd0, mIdle});
      checkOutput("stall", {63'd0, stall}, {63'd0, !mIdle});
      checkOutput("wb_valid", {63'd0, wb_valid}, {63'd0, mValid});
      checkOutput("core_start", {63'd0, core_start}, {63'd0, mStart});
      checkOutput("core_abort", {63'd0, core_abort}, {63'd0, mAbort});
      if (mValid) begin
        checkOutput("wb_data", wb_data, mData);
        checkOutput("wb_rd", {59'd0, wb_rd}, {59'd0, mRd});
      end
      if (mRun) begin
        checkOutput("core_dividend", core_dividend, mDiv);
        checkOutput("core_divisor", core_divisor, mDvs);
      end

      mStart = 1'b0;
      mAbort = 1'b0;
      if (flush) begin
        mAbort = mRun;
        mRun   = 1'b0;
        mFix   = 1'b0;
        mValid = 1'b0;
      end else if (mIdle && ex_valid) begin
        pendData = refResult(ex_funct3, ex_word, ex_rs1, ex_rs2);
        pendRd   = ex_rd;
        if (refSpecial(ex_funct3, ex_word, ex_rs1, ex_rs2)) begin
          mValid = 1'b1;
          mData  = pendData;
          mRd    = pendRd;
        end else begin
          mRun   = 1'b1;
          mStart = 1'b1;
          mDiv   = refMag(ex_funct3, ex_word, ex_rs1);
          mDvs   = refMag(ex_funct3, ex_word, ex_rs2);
        end
      end else if (mRun && core_done) begin
        mRun = 1'b0;
        mFix = 1'b1;
      end else if (mFix) begin
        mFix   = 1'b0;
        mValid = 1'b1;
        mData  = pendData;
        mRd    = pendRd;
      end else if (mValid && wb_ready) begin
        mValid = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] rd, input int lat);
    int g = 0;
    while (ex_ready !== 1'b1 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 400) checkOutput("ex_ready_timeout", {63'd0, ex_ready}, 64'd1);
    coreLatency = lat;
    ex_valid  = 1'b1;
    ex_funct3 = f3;
    ex_word   = w;
    ex_rs1    = a;
    ex_rs2    = b;
    ex_rd     = rd;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic waitResult(input int hold, output logic [63:0] data);
    int g = 0;
    while (wb_valid !== 1'b1 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("wb_valid_arrives", {63'd0, wb_valid}, 64'd1);
    data = wb_data;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input int lat, input logic [63:0] expected);
    logic [63:0] data;
    checkOutput({name, "_model"}, refResult(f3, w, a, b), expected);
    applyStimulus(f3, w, a, b, rd, lat);
    waitResult(0, data);
    checkOutput(name, data, expected);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [63:0] data;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    int          sel;
    int          g;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ex_ready", {63'd0, ex_ready}, 64'd1);
    checkOutput("reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("reset_core_start", {63'd0, core_start}, 64'd0);
    checkOutput("reset_core_abort", {63'd0, core_abort}, 64'd0);
    checkOutput("reset_wb_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("reset_wb_data", wb_data, 64'd0);
    checkOutput("reset_wb_rd", {59'd0, wb_rd}, 64'd0);
    checkOutput("reset_core_dividend", core_dividend, 64'd0);
    checkOutput("reset_core_divisor", core_divisor, 64'd0);
    rst = 1'b0;
    modelOn = 1'b1;
    @(posedge clk);
    #1;

    // Signed divide of a negative dividend.
    applyStimulus(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 3);
    checkOutput("div_neg_core_dividend", core_dividend, 64'd7);
    waitResult(0, data);
    checkOutput("div_neg", data, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("rem_neg", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 4, 64'hFFFF_FFFF_FFFF_FFFF);

    // Divide by zero: answered without the core, one cycle after accept.
    applyStimulus(DIVU, 1'b0, 64'h1234, 64'd0, 5'd3, 3);
    checkOutput("divz_latency", {63'd0, wb_valid}, 64'd1);
    checkOutput("divz_no_start", {63'd0, core_start}, 64'd0);
    waitResult(0, data);
    checkOutput("divu_zero", data, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("remu_zero", REMU, 1'b0, 64'h1234, 64'd0, 5'd4, 3, 64'h1234);

    // Signed overflow in both widths.
    runOp("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 3,
          64'h8000_0000_0000_0000);
    runOp("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 3, 64'd0);
    runOp("divw_ovf", DIV, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd7, 3,
          64'hFFFF_FFFF_8000_0000);

    // Unsigned word forms.
    applyStimulus(DIVU, 1'b1, 64'hAAAA_AAAA_FFFF_FFFF, 64'd1, 5'd8, 5);
    checkOutput("divuw_core_dividend", core_dividend, 64'h0000_0000_FFFF_FFFF);
    waitResult(0, data);
    checkOutput("divuw", data, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("remuw", REMU, 1'b1, 64'd7, 64'd3, 5'd9, 2, 64'd1);

    // Long core latency with a slow writeback consumer.
    applyStimulus(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9, 5'd10, 64);
    g = 0;
    while (wb_valid !== 1'b1 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("slow_latency", g, 64'd66);
    repeat (5) begin
      checkOutput("slow_data", wb_data, 64'hFFFF_FFFF_FFFF_FFF5);
      checkOutput("slow_ex_ready", {63'd0, ex_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    checkOutput("slow_ready_after", {63'd0, ex_ready}, 64'd1);

    // Flush mid-run; the core keeps going and answers late.
    honourAbort = 1'b0;
    applyStimulus(DIV, 1'b0, 64'd1000, 64'd7, 5'd11, 64);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_abort", {63'd0, core_abort}, 64'd1);
    checkOutput("flush_idle", {63'd0, ex_ready}, 64'd1);
    @(posedge clk);
    #1;
    checkOutput("flush_abort_single", {63'd0, core_abort}, 64'd0);
    runOp("after_flush", DIVU, 1'b0, 64'd100, 64'd7, 5'd12, 5, 64'd14);
    repeat (70) begin
      @(posedge clk);
      #1;
    end
    honourAbort = 1'b1;

    // Flush together with a request in IDLE: nothing accepted.
    ex_valid = 1'b1;
    ex_funct3 = DIVU;
    ex_rs1 = 64'd50;
    ex_rs2 = 64'd0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    flush = 1'b0;
    checkOutput("idle_flush_no_accept", {63'd0, ex_ready}, 64'd1);
    checkOutput("idle_flush_no_valid", {63'd0, wb_valid}, 64'd0);

    // Flush coincident with wb_ready in RESP: result dropped.
    applyStimulus(DIVU, 1'b0, 64'd5, 64'd0, 5'd13, 3);
    wb_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    flush = 1'b0;
    checkOutput("resp_flush_valid", {63'd0, wb_valid}, 64'd0);

    // Randomized traffic with random backpressure and flushes.
    for (int n = 0; n < 150; n++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      sel = $urandom_range(0, 19);
      if (sel < 2) begin
        b = w ? {$urandom, 32'd0} : 64'd0;
      end else if (sel == 2) begin
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
      end else if (sel < 7) begin
        b = 64'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end else if (sel == 7) begin
        a = 64'($urandom_range(0, 50));
      end
      applyStimulus(f3, w, a, b, 5'(n), $urandom_range(1, 12));
      g = 0;
      while (ex_ready !== 1'b1 && g < 300) begin
        wb_ready = ($urandom_range(0, 2) != 0);
        flush    = ($urandom_range(0, 49) == 0);
        @(posedge clk);
        #1;
        g++;
      end
      wb_ready = 1'b0;
      flush    = 1'b0;
      if (g >= 300) checkOutput("random_timeout", {63'd0, ex_ready}, 64'd1);
    end

    repeat (3) @(posedge clk);
    #1;
    modelOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Execute-stage requester for the RV64M divide/remainder path: accepts DIV/DIVU/REM/REMU and their W forms from the EX pipeline. It resolves RISC-V special cases locally, hands unsigned magnitudes to the iterative divider core, and waits for completion. It then applies sign correction and word sign-extension, and returns the result to writeback through a valid/ready handshake, holding `stall` for the duration.

## Interface
- No parameters; XLEN fixed at 64.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1 / `ex_ready` out 1: request handshake; transfer on both high.
- `ex_funct3` in 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are never presented.
- `ex_word` in 1: W form; only the low 32 operand bits are used, and the 32-bit result is sign-extended.
- `ex_rs1`, `ex_rs2` in 64: dividend and divisor.
- `ex_rd` in 5: destination tag, returned unchanged.
- `flush` in 1: abort the current operation.
- `stall` out 1: high in every non-IDLE state.
- `core_start` out 1: one-cycle launch pulse.
- `core_dividend`, `core_divisor` out 64: unsigned magnitudes, stable from start until done.
- `core_abort` out 1: one-cycle cancel pulse.
- `core_done` in 1: completion pulse from the core.
- `core_quot`, `core_rem` in 64: unsigned core results, valid with `core_done`.
- `wb_valid` out 1 / `wb_ready` in 1: response handshake.
- `wb_data` out 64: final result.
- `wb_rd` out 5: destination tag.

## Operation
- FSM states: IDLE, RUN, FIX, RESP.
- `ex_ready` = 1 only in IDLE. No overlap: one operation in flight at a time.
- IDLE accept:
  - Register the operands, funct3, word flag and rd.
  - For W forms, reduce the operands to 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
- Special cases, checked on the reduced operands at accept:
  - Divisor == 0: quotient = all ones; remainder = dividend (W forms: low word, sign-extended).
  - Signed overflow (dividend = most-negative value, divisor = −1): quotient = dividend; remainder = 0.
  - On either case: go directly to RESP; `core_start` is never raised.
- Normal path: IDLE → RUN.
  - `core_start` is high in the first RUN cycle only.
  - The core operands are |a| and |b| for signed ops, raw values otherwise.
- RUN:
  - Wait for `core_done`; `core_done` is sampled only in RUN.
  - On `core_done`, capture `core_quot` / `core_rem` and go to FIX.
- FIX:
  - Negate the quotient if the op is signed and sign(a) ≠ sign(b).
  - Negate the remainder if the op is signed and sign(a) = 1.
  - Select quotient or remainder per funct3[1].
  - W forms: sign-extend bit 31 into bits 63:32.
  - Register into `wb_data`, then go to RESP.
- RESP:
  - `wb_valid` is held with `wb_data` / `wb_rd` stable until `wb_ready`.
  - On handshake, go to IDLE.
- Flush:
  - From any state, go to IDLE on the next edge.
  - `wb_valid` drops.
  - `core_abort` pulses one cycle if flush arrives in RUN.
  - A `core_done` arriving after the flush is ignored.
  - A flush coincident with `ex_valid` in IDLE: the request is not accepted.
- Flush and `core_done` in the same RUN cycle: flush wins.
- Flush and `wb_ready` in the same RESP cycle: flush wins; the result counts as not delivered.

## Timing
- Reset values: state IDLE; `ex_ready` = 1; `stall`, `core_start`, `core_abort`, `wb_valid` = 0; `wb_data` = 0, `wb_rd` = 0, `core_dividend` = 0, `core_divisor` = 0.
- Special-case latency: accept at cycle T → `wb_valid` at T+1.
- Normal latency: accept at T → `core_start` at T+1 → `core_done` at T+1+N → FIX at T+2+N → `wb_valid` at T+3+N.
- The earliest next accept is the cycle after the `wb_valid`/`wb_ready` handshake.
- `stall` is combinational from the state register.
- All other outputs are registered.

## Structure
- Shared package holds:
  - funct3 constants DIV/DIVU/REM/REMU;
  - the FSM state enum;
  - the XLEN constant;
  - reset-enable and zero-word constants.
- One natural sub-module, `div_sign_fix`: combinational magnitude/negate/select/sign-extend logic, used in FIX and for the special-case result.

## Test plan
- DIV rs1 = 0xFFFF_FFFF_FFFF_FFF9 (−7), rs2 = 2; core returns quot 3, rem 1 → `core_dividend` = 7, `wb_data` = 0xFFFF_FFFF_FFFF_FFFD; REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU rs1 = 0x1234, rs2 = 0 → no `core_start`, `wb_valid` at T+1, `wb_data` = 0xFFFF_FFFF_FFFF_FFFF; REMU with the same operands → 0x1234.
- DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → `wb_data` = 0x8000_0000_0000_0000; REM → 0; DIVW rs1 = 0x0000_0001_8000_0000, rs2 = 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- DIVUW rs1 = 0xAAAA_AAAA_FFFF_FFFF, rs2 = 1 → `core_dividend` = 0xFFFF_FFFF; core returns quot 0xFFFF_FFFF → `wb_data` = 0xFFFF_FFFF_FFFF_FFFF; REMUW 7 mod 3 → 1.
- Normal DIV with core latency N = 64 and `wb_ready` held low 5 cycles → `stall` high throughout, `wb_data` stable, `ex_ready` low until the cycle after the handshake.
- Flush at RUN cycle 10, followed by a stale `core_done` 54 cycles later → `core_abort` single pulse, IDLE next cycle, no `wb_valid`; a new request accepted meanwhile completes with its own result.
